apb_master_arbiter: RTL

Shares one APB3 master port among NREQ local requesters, such as a BFM command engine, a DMA-style test sequencer or a debug poke port. It arbitrates round-robin, sequences the APB SETUP/ACCESS phases, honours PREADY wait states and reports PSLVERR. It decodes the slot PSEL from the address and aborts hung transfers with a timeout. It sits between requester logic and the 16-slot APB fabric driven in BFM/testbench systems.

---
 rtl/apb_master_arbiter_pkg.sv | 22 ++
 rtl/apb_master_arbiter_if.sv | 40 ++++
 rtl/apb_master_arbiter_rr_arbiter.sv | 30 +++
 rtl/apb_master_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and constants for the APB master arbiter.
// Holds the FSM encoding and the APB slot-select geometry.
package apb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int SLOT_W = 4;
    localparam int PSEL_W = 16;

    function automatic logic [PSEL_W-1:0] slot_onehot(
        input logic [SLOT_W-1:0] slot
    );
        logic [PSEL_W-1:0] r;
        r = PSEL_W'(1) << slot;
        return r;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter.
// master = the arbiter, slave = requesters plus APB fabric.
interface apb_master_arbiter_if #(
    parameter int NREQ = 4
);
    import apb_master_arbiter_pkg::*;

    logic [NREQ-1:0]    REQ;
    logic [NREQ*32-1:0] REQ_ADDR;
    logic [NREQ-1:0]    REQ_WRITE;
    logic [NREQ*32-1:0] REQ_WDATA;
    logic [NREQ-1:0]    DONE;
    logic [31:0]        RDATA;
    logic               ERR;
    logic               TOUT;

    logic [PSEL_W-1:0]  PSEL;
    logic [31:0]        PADDR;
    logic               PWRITE;
    logic               PENABLE;
    logic [31:0]        PWDATA;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport master (
        input  REQ, REQ_ADDR, REQ_WRITE, REQ_WDATA,
        input  PRDATA, PREADY, PSLVERR,
        output DONE, RDATA, ERR, TOUT,
        output PSEL, PADDR, PWRITE, PENABLE, PWDATA
    );

    modport slave (
        output REQ, REQ_ADDR, REQ_WRITE, REQ_WDATA,
        output PRDATA, PREADY, PSLVERR,
        input  DONE, RDATA, ERR, TOUT,
        input  PSEL, PADDR, PWRITE, PENABLE, PWDATA
    );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr,
// searching upward and wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [IW-1:0]   o_win,
    output logic            o_valid
);

    // Walk offsets from far to near so the nearest hit wins.
    always_comb begin
        int k;
        k       = 0;
        o_win   = '0;
        o_valid = |i_req;
        for (int d = NREQ - 1; d >= 0; d--) begin
            k = int'(i_ptr) + d;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (i_req[IW'(k)]) begin
                o_win = IW'(k);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB3 master shared by NREQ requesters, with slot
// decode, wait-state handling and an ACCESS-phase timeout.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SLOT_LSB = 24,
    parameter int TIMEOUT  = 255,
    parameter int TOW      = 8
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_master_arbiter_if.master bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t            r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_win;
    logic [TOW-1:0]    r_cnt;
    logic [PSEL_W-1:0] r_psel;
    logic [31:0]       r_paddr;
    logic              r_pwrite;
    logic              r_penable;
    logic [31:0]       r_pwdata;
    logic [NREQ-1:0]   r_done;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_tout;

    logic [IW-1:0]     w_win;
    logic              w_valid;
    logic [IW-1:0]     w_ptr_nxt;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_write;
    logic [TOW-1:0]    w_cnt_nxt;
    logic              w_tout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .i_req   (bus.REQ),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    assign w_addr    = bus.REQ_ADDR[{w_win, 5'd0} +: 32];
    assign w_wdata   = bus.REQ_WDATA[{w_win, 5'd0} +: 32];
    assign w_write   = bus.REQ_WRITE[w_win];
    assign w_ptr_nxt = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    // A zero TIMEOUT leaves the counter free-running but never aborts.
    assign w_cnt_nxt  = r_cnt + 1'b1;
    assign w_tout_hit = (TIMEOUT != 0) && (w_cnt_nxt == TOW'(TIMEOUT));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            r_psel    <= '0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_penable <= 1'b0;
            r_pwdata  <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_tout    <= 1'b0;
        end else begin
            r_done <= '0;
            r_tout <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_win     <= w_win;
                        r_paddr   <= w_addr;
                        r_pwrite  <= w_write;
                        r_pwdata  <= w_wdata;
                        r_psel    <= slot_onehot(w_addr[SLOT_LSB +: SLOT_W]);
                        r_penable <= 1'b0;
                        r_ptr     <= w_ptr_nxt;
                        r_cnt     <= '0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.PREADY) begin
                        r_done    <= ONE << r_win;
                        r_err     <= bus.PSLVERR;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (!r_pwrite) begin
                            r_rdata <= bus.PRDATA;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_tout_hit) begin
                            r_done    <= ONE << r_win;
                            r_tout    <= 1'b1;
                            r_err     <= 1'b1;
                            r_rdata   <= '0;
                            r_psel    <= '0;
                            r_penable <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.DONE    = r_done;
    assign bus.RDATA   = r_rdata;
    assign bus.ERR     = r_err;
    assign bus.TOUT    = r_tout;
    assign bus.PSEL    = r_psel;
    assign bus.PADDR   = r_paddr;
    assign bus.PWRITE  = r_pwrite;
    assign bus.PENABLE = r_penable;
    assign bus.PWDATA  = r_pwdata;

endmodule
